// File: rtl/pool2x2_stream.sv
// pool2x2_stream: 2x2 stride-2 max/avg pooling of a raster pixel stream via a half-width line buffer.
// Output registered 1 cycle after the bottom-right pixel; no backpressure. Optional macro POOL_RELU_EN clamps negative results.
module pool2x2_stream #(
    parameter int DATA_W   = 16,
    parameter int MAX_COLS = 256,
    parameter int DIM_W    = 9
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic [DIM_W-1:0]         cfg_cols,
    input  logic [DIM_W-1:0]         cfg_rows,
    input  logic                     cfg_avg,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     cfg_err
);
    localparam int DEPTH  = MAX_COLS / 2;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DIM_W:0] MAX_COLS_W = (DIM_W+1)'(MAX_COLS);

    logic [DIM_W-1:0]         col_q, col_d, row_q, row_d;
    logic [DIM_W-1:0]         cols_q, cols_d, rows_q, rows_d;
    logic                     avg_q, avg_d, ok_q, ok_d, err_q, err_d;
    logic signed [DATA_W-1:0] p0_q, p0_d;
    logic                     out_vld_q, out_vld_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;
    logic signed [DATA_W-1:0] out_dat_q, out_dat_d;

    logic signed [DATA_W:0]   mem [DEPTH];
    logic signed [DATA_W:0]   buf_rd_q;

    logic                     sof, cfg_legal, avg_e, ok_e;
    logic [DIM_W-1:0]         cols_e, rows_e, pos_c, pos_r;
    logic                     odd_c, odd_r, last_c, last_r, fire;
    logic signed [DATA_W:0]   p0x, inx, h;
    logic signed [DATA_W+1:0] bx, hx, vsum, vmax;
    logic signed [DATA_W-1:0] res, res_f;
    logic                     buf_we, buf_re;
    logic [ADDR_W-1:0]        buf_addr;

    assign cfg_legal = (cfg_cols >= DIM_W'(2)) && (cfg_rows >= DIM_W'(2)) &&
                       ({1'b0, cfg_cols} <= MAX_COLS_W);

    // A start-of-frame pixel uses the incoming configuration and sits at (0,0).
    always_comb begin
        sof    = in_valid && in_sof;
        cols_e = sof ? cfg_cols : cols_q;
        rows_e = sof ? cfg_rows : rows_q;
        avg_e  = sof ? cfg_avg : avg_q;
        ok_e   = sof ? cfg_legal : ok_q;
        pos_c  = sof ? '0 : col_q;
        pos_r  = sof ? '0 : row_q;
        odd_c  = pos_c[0];
        odd_r  = pos_r[0];
        last_c = (pos_c == cols_e - DIM_W'(1));
        last_r = (pos_r == rows_e - DIM_W'(1));

        p0x  = {p0_q[DATA_W-1], p0_q};
        inx  = {in_data[DATA_W-1], in_data};
        h    = avg_e ? (p0x + inx) : ((p0_q > in_data) ? p0x : inx);
        bx   = {buf_rd_q[DATA_W], buf_rd_q};
        hx   = {h[DATA_W], h};
        vsum = bx + hx;
        vmax = (bx > hx) ? bx : hx;
        res  = avg_e ? DATA_W'(vsum >>> 2) : DATA_W'(vmax);
`ifdef POOL_RELU_EN
        res_f = res[DATA_W-1] ? '0 : res;
`else
        res_f = res;
`endif

        fire     = in_valid && ok_e && odd_c && odd_r;
        // A trailing odd row is never stored; it has no partner row.
        buf_we   = in_valid && ok_e && odd_c && !odd_r && !last_r;
        buf_re   = in_valid && ok_e && !odd_c && odd_r;
        buf_addr = ADDR_W'(pos_c >> 1);
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        cols_d    = cols_q;
        rows_d    = rows_q;
        avg_d     = avg_q;
        ok_d      = ok_q;
        err_d     = err_q;
        p0_d      = p0_q;
        out_vld_d = 1'b0;
        out_eol_d = 1'b0;
        out_eof_d = 1'b0;
        out_dat_d = out_dat_q;
        if (in_valid) begin
            cols_d = cols_e;
            rows_d = rows_e;
            avg_d  = avg_e;
            ok_d   = ok_e;
            if (sof) begin
                err_d = !cfg_legal;
            end
            if (!odd_c) begin
                p0_d = in_data;
            end
            if (last_c) begin
                col_d = '0;
                row_d = last_r ? '0 : pos_r + DIM_W'(1);
            end else begin
                col_d = pos_c + DIM_W'(1);
                row_d = pos_r;
            end
            if (fire) begin
                out_vld_d = 1'b1;
                out_dat_d = res_f;
                out_eol_d = ((pos_c >> 1) == (cols_e >> 1) - DIM_W'(1));
                out_eof_d = ((pos_c >> 1) == (cols_e >> 1) - DIM_W'(1)) &&
                            ((pos_r >> 1) == (rows_e >> 1) - DIM_W'(1));
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            cols_q    <= '0;
            rows_q    <= '0;
            avg_q     <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            p0_q      <= '0;
            out_vld_q <= 1'b0;
            out_eol_q <= 1'b0;
            out_eof_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            cols_q    <= cols_d;
            rows_q    <= rows_d;
            avg_q     <= avg_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            p0_q      <= p0_d;
            out_vld_q <= out_vld_d;
            out_eol_q <= out_eol_d;
            out_eof_q <= out_eof_d;
            out_dat_q <= out_dat_d;
        end
    end

    // Single-port line buffer: even rows write, odd rows read one pixel ahead.
    always_ff @(posedge pclk) begin
        if (buf_we) begin
            mem[buf_addr] <= h;
        end else if (buf_re) begin
            buf_rd_q <= mem[buf_addr];
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: directed and randomized frames compared against a window-level reference model.
module tb_pool2x2_stream;
    localparam int DATA_W   = 16;
    localparam int MAX_COLS = 256;
    localparam int DIM_W    = 9;

    logic                     pclk = 1'b0;
    logic                     rst;
    logic [DIM_W-1:0]         cfg_cols, cfg_rows;
    logic                     cfg_avg, in_valid, in_sof;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid, out_eol, out_eof, cfg_err;
    logic signed [DATA_W-1:0] out_data;

    pool2x2_stream #(.DATA_W(DATA_W), .MAX_COLS(MAX_COLS), .DIM_W(DIM_W)) dut (
        .pclk(pclk), .rst(rst), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_avg(cfg_avg),
        .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_eol(out_eol), .out_eof(out_eof),
        .cfg_err(cfg_err)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic signed [DATA_W-1:0] d;
        logic                     eol;
        logic                     eof;
        logic [31:0]              t;
    } rec_t;

    rec_t        obs_q[$];
    rec_t        exp_q[$];
    int          pix[$];
    int unsigned acc_q[$];
    int          checks = 0;
    int          passes = 0;
    int unsigned cyc = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (rst === 1'b0 && out_valid === 1'b1) obs_q.push_back({out_data, out_eol, out_eof, cyc});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic fill_seq(input int n);
        pix.delete();
        for (int i = 0; i < n; i++) pix.push_back(i);
    endtask

    task automatic drive_frame(input int cols, input int rows, input bit avg, input int npix,
                               input int gap_pct, input bit with_sof);
        int k = 0;
        acc_q.delete();
        cfg_cols = DIM_W'(cols);
        cfg_rows = DIM_W'(rows);
        cfg_avg  = avg;
        while (k < npix) begin
            @(negedge pclk);
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_sof   = with_sof && (k == 0);
                in_data  = DATA_W'(pix[k]);
                acc_q.push_back(cyc);
                k++;
            end
        end
        @(negedge pclk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    // Reference: enumerate complete 2x2 windows and pool them arithmetically.
    task automatic build_exp(input int cols, input int rows, input bit avg);
        exp_q.delete();
        for (int r = 1; r < rows; r += 2) begin
            for (int c = 1; c < cols; c += 2) begin
                int a, b, d, e, v;
                rec_t x;
                a = pix[(r-1)*cols + c-1];
                b = pix[(r-1)*cols + c];
                d = pix[r*cols + c-1];
                e = pix[r*cols + c];
                if (avg) begin
                    v = a + b + d + e;
                    v = (v >= 0) ? v / 4 : -((-v + 3) / 4);
                end else begin
                    v = a;
                    if (b > v) v = b;
                    if (d > v) v = d;
                    if (e > v) v = e;
                end
`ifdef POOL_RELU_EN
                if (v < 0) v = 0;
`endif
                x.d   = DATA_W'(v);
                x.eol = (c + 2 >= cols);
                x.eof = x.eol && (r + 2 >= rows);
                x.t   = 32'(acc_q[r*cols + c] + 1);
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        cfg_cols = '0; cfg_rows = '0; cfg_avg = 1'b0;
        repeat (3) @(negedge pclk);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %0b want 0", out_valid); else passes++;
        checks++; if (out_data !== '0) $display("FAIL reset out_data: got %0d want 0", out_data); else passes++;
        checks++; if (out_eol !== 1'b0) $display("FAIL reset out_eol: got %0b want 0", out_eol); else passes++;
        checks++; if (out_eof !== 1'b0) $display("FAIL reset out_eof: got %0b want 0", out_eof); else passes++;
        checks++; if (cfg_err !== 1'b0) $display("FAIL reset cfg_err: got %0b want 0", cfg_err); else passes++;
        rst = 1'b0;
        repeat (2) @(negedge pclk);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset idle out_valid: got %0b want 0", out_valid); else passes++;
    endtask

    task automatic test_max_4x4();
        int want[4] = '{5, 7, 13, 15};
        obs_q.delete();
        fill_seq(16);
        drive_frame(4, 4, 1'b0, 16, 0, 1'b1);
        build_exp(4, 4, 1'b0);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL max4x4 count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL max4x4 out%0d: got d=%0d eol=%0b eof=%0b t=%0d want d=%0d eol=%0b eof=%0b t=%0d",
                i, obs_q[i].d, obs_q[i].eol, obs_q[i].eof, obs_q[i].t, exp_q[i].d, exp_q[i].eol, exp_q[i].eof, exp_q[i].t);
            else passes++;
            checks++;
            if (obs_q[i].d !== DATA_W'(want[i])) $display("FAIL max4x4 value%0d: got %0d want %0d", i, obs_q[i].d, want[i]);
            else passes++;
        end
    endtask

    task automatic test_avg();
        obs_q.delete();
        fill_seq(16);
        drive_frame(4, 4, 1'b1, 16, 0, 1'b1);
        build_exp(4, 4, 1'b1);
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(-1);
        for (int w = 0; w < 4; w++) begin
            int r0, c0, pick;
            r0 = (w / 2) * 2;
            c0 = (w % 2) * 2;
            pick = int'($urandom_range(3));
            pix[(r0 + pick / 2) * 4 + c0 + pick % 2] = -2;
        end
        begin
            rec_t first_q[$];
            first_q = exp_q;
            drive_frame(4, 4, 1'b1, 16, 0, 1'b1);
            build_exp(4, 4, 1'b1);
            exp_q = {first_q, exp_q};
        end
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL avg count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL avg out%0d: got d=%0d eol=%0b eof=%0b t=%0d want d=%0d eol=%0b eof=%0b t=%0d",
                i, obs_q[i].d, obs_q[i].eol, obs_q[i].eof, obs_q[i].t, exp_q[i].d, exp_q[i].eol, exp_q[i].eof, exp_q[i].t);
            else passes++;
        end
    endtask

    task automatic test_odd_dims();
        obs_q.delete();
        fill_seq(15);
        drive_frame(5, 3, 1'b0, 15, 0, 1'b1);
        build_exp(5, 3, 1'b0);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL odd5x3 count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL odd5x3 out%0d: got d=%0d eol=%0b eof=%0b t=%0d want d=%0d eol=%0b eof=%0b t=%0d",
                i, obs_q[i].d, obs_q[i].eol, obs_q[i].eof, obs_q[i].t, exp_q[i].d, exp_q[i].eol, exp_q[i].eof, exp_q[i].t);
            else passes++;
        end
    endtask

    task automatic test_gaps();
        obs_q.delete();
        fill_seq(16);
        drive_frame(4, 4, 1'b0, 16, 50, 1'b1);
        build_exp(4, 4, 1'b0);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL gaps count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL gaps out%0d: got d=%0d eol=%0b eof=%0b t=%0d want d=%0d eol=%0b eof=%0b t=%0d",
                i, obs_q[i].d, obs_q[i].eol, obs_q[i].eof, obs_q[i].t, exp_q[i].d, exp_q[i].eol, exp_q[i].eof, exp_q[i].t);
            else passes++;
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== DATA_W'(15)) $display("FAIL gaps hold: got valid=%0b data=%0d want valid=0 data=15", out_valid, out_data);
        else passes++;
    endtask

    task automatic test_resync();
        obs_q.delete();
        fill_seq(16);
        for (int i = 0; i < 16; i++) pix[i] = 100 + i;
        drive_frame(4, 4, 1'b0, 5, 0, 1'b1);
        fill_seq(16);
        drive_frame(4, 4, 1'b0, 16, 0, 1'b1);
        build_exp(4, 4, 1'b0);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL resync count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL resync out%0d: got d=%0d eol=%0b eof=%0b t=%0d want d=%0d eol=%0b eof=%0b t=%0d",
                i, obs_q[i].d, obs_q[i].eol, obs_q[i].eof, obs_q[i].t, exp_q[i].d, exp_q[i].eol, exp_q[i].eof, exp_q[i].t);
            else passes++;
        end
    endtask

    task automatic test_cfg_err();
        obs_q.delete();
        fill_seq(24);
        drive_frame(MAX_COLS + 2, 2, 1'b0, 24, 0, 1'b1);
        checks++; if (cfg_err !== 1'b1) $display("FAIL cfgerr wide: got %0b want 1", cfg_err); else passes++;
        checks++; if (obs_q.size() != 0) $display("FAIL cfgerr wide outputs: got %0d want 0", obs_q.size()); else passes++;
        drive_frame(4, 1, 1'b0, 8, 0, 1'b1);
        checks++; if (cfg_err !== 1'b1) $display("FAIL cfgerr rows1: got %0b want 1", cfg_err); else passes++;
        drive_frame(1, 4, 1'b0, 8, 0, 1'b1);
        checks++; if (cfg_err !== 1'b1) $display("FAIL cfgerr cols1: got %0b want 1", cfg_err); else passes++;
        checks++; if (obs_q.size() != 0) $display("FAIL cfgerr small outputs: got %0d want 0", obs_q.size()); else passes++;
        fill_seq(16);
        drive_frame(4, 4, 1'b0, 16, 0, 1'b1);
        build_exp(4, 4, 1'b0);
        checks++; if (cfg_err !== 1'b0) $display("FAIL cfgerr clear: got %0b want 0", cfg_err); else passes++;
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL cfgerr legal count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL cfgerr legal out%0d: got d=%0d t=%0d want d=%0d t=%0d", i, obs_q[i].d, obs_q[i].t, exp_q[i].d, exp_q[i].t);
            else passes++;
        end
    endtask

    task automatic test_rst_mid();
        obs_q.delete();
        fill_seq(16);
        drive_frame(4, 4, 1'b0, 5, 0, 1'b1);
        @(negedge pclk);
        in_valid = 1'b1; in_sof = 1'b0; in_data = DATA_W'(5);
        @(posedge pclk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid out_valid: got %0b want 0", out_valid); else passes++;
        checks++; if (out_data !== '0) $display("FAIL rstmid out_data: got %0d want 0", out_data); else passes++;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        drive_frame(4, 4, 1'b0, 16, 0, 1'b0);
        checks++; if (obs_q.size() != 0) $display("FAIL rstmid nosof outputs: got %0d want 0", obs_q.size()); else passes++;
        drive_frame(4, 4, 1'b0, 16, 0, 1'b1);
        build_exp(4, 4, 1'b0);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rstmid count: got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL rstmid out%0d: got d=%0d t=%0d want d=%0d t=%0d", i, obs_q[i].d, obs_q[i].t, exp_q[i].d, exp_q[i].t);
            else passes++;
        end
    endtask

    task automatic test_relu();
        int want;
`ifdef POOL_RELU_EN
        want = 0;
`else
        want = -3;
`endif
        obs_q.delete();
        pix = '{-8, -3, -4, -9};
        drive_frame(2, 2, 1'b0, 4, 0, 1'b1);
        build_exp(2, 2, 1'b0);
        checks++; if (obs_q.size() != 1) $display("FAIL relu count: got %0d want 1", obs_q.size()); else passes++;
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== exp_q[0]) $display("FAIL relu model: got d=%0d eol=%0b eof=%0b t=%0d want d=%0d eol=%0b eof=%0b t=%0d",
                obs_q[0].d, obs_q[0].eol, obs_q[0].eof, obs_q[0].t, exp_q[0].d, exp_q[0].eol, exp_q[0].eof, exp_q[0].t);
            else passes++;
            checks++;
            if (obs_q[0].d !== DATA_W'(want)) $display("FAIL relu value: got %0d want %0d", obs_q[0].d, want);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int cols, rows, gap;
            bit avg;
            cols = int'($urandom_range(11, 2));
            rows = int'($urandom_range(7, 2));
            gap  = int'($urandom_range(60));
            avg  = 1'($urandom_range(1));
            pix.delete();
            for (int i = 0; i < cols * rows; i++) begin
                logic signed [DATA_W-1:0] t;
                t = DATA_W'($urandom);
                pix.push_back(int'(t));
            end
            obs_q.delete();
            drive_frame(cols, rows, avg, cols * rows, gap, 1'b1);
            build_exp(cols, rows, avg);
            checks++;
            if (obs_q.size() != exp_q.size()) $display("FAIL random f%0d %0dx%0d count: got %0d want %0d", f, cols, rows, obs_q.size(), exp_q.size());
            else passes++;
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL random f%0d out%0d: got d=%0d eol=%0b eof=%0b t=%0d want d=%0d eol=%0b eof=%0b t=%0d",
                    f, i, obs_q[i].d, obs_q[i].eol, obs_q[i].eof, obs_q[i].t, exp_q[i].d, exp_q[i].eol, exp_q[i].eof, exp_q[i].t);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_max_4x4();
        test_avg();
        test_odd_dims();
        test_gaps();
        test_resync();
        test_cfg_err();
        test_rst_mid();
        test_relu();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
